// File: rtl/rr_arbiter4_pkg.sv
// arb_pkg: shared sizes and FSM state type for the round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = 8;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between requesters (master) and arbiter (slave).
interface rr_arbiter4_if;
    import arb_pkg::*;
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic             timeout;
    modport master(output req, done, input gnt, gnt_valid, timeout);
    modport slave(input req, done, output gnt, gnt_valid, timeout);
endinterface

// File: rtl/rr_pick4.sv
// rr_pick4: rotate-and-select, first set request after ptr with wrap-around.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [IDX_W-1:0] idx_o
);
    // Scan farthest-first so the nearest requester after ptr wins last.
    always_comb begin
        idx_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req_i[ptr_i + IDX_W'(k + 1)]) idx_o = ptr_i + IDX_W'(k + 1);
        pick_o = req_i[idx_o] ? N_REQ'(1) << idx_o : '0;
    end
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter with registered grant, release and hold timeout.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input logic          clk,
    input logic          rst_n,
    rr_arbiter4_if.slave arb_io
);
    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, pick;
    logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, pick_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d, vld_q, vld_d;
    logic             rel, expire;

    rr_pick4 u_pick (
        .req_i (arb_io.req),
        .ptr_i (ptr_q),
        .pick_o(pick),
        .idx_o (pick_idx)
    );

    assign rel    = arb_io.done || !arb_io.req[idx_q];
    assign expire = cnt_q == CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = |arb_io.req ? GRANT : IDLE;
        else if (rel || expire) state_d = IDLE;
    end

    // Release takes priority over expiry, so timeout only fires when no release holds.
    always_comb begin
        gnt_d = '0;
        idx_d = idx_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        tmo_d = 1'b0;
        if (state_q == IDLE) begin
            if (|arb_io.req) begin
                gnt_d = pick;
                idx_d = pick_idx;
                cnt_d = '0;
            end
        end else if (rel || expire) begin
            ptr_d = idx_q;
            tmo_d = !rel;
        end else begin
            gnt_d = gnt_q;
            cnt_d = cnt_q + CNT_W'(1);
        end
        vld_d = |gnt_d;
    end

    assign arb_io.gnt       = gnt_q;
    assign arb_io.gnt_valid = vld_q;
    assign arb_io.timeout   = tmo_q;
endmodule
